ro_puf_engine: RTL and testbench

- Parametrised ring-oscillator PUF measurement engine.
- Drives enable and delay-path configuration to an array of NUM_RO ring oscillators.
- Counts each oscillator's rising edges in the CLK domain over a fixed window, then compares adjacent pairs to form a NUM_RO/2-bit response, delivered over a valid/ready handshake.
- Sits between the oscillator array and the challenge/response logic.

---
 rtl/ro_puf_engine.sv | 155 +++++++++++++++
 tb/tb_ro_puf_engine.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ro_puf_engine.sv
`default_nettype none
// ============================================================================
// Module      : ro_puf_engine
// Description : Ring-oscillator PUF measurement engine. Counts pair-wise
//               oscillator edges over a fixed window and compares each pair.
// Revision    : 1.0 - initial release
// ============================================================================
module ro_puf_engine #(
    parameter int NUM_RO   = 8,
    parameter int OSC_SIZE = 16,
    parameter int CNT_W    = 16,
    parameter int WINDOW   = 1024,
    parameter int SETTLE   = 16
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [OSC_SIZE-1:0]   cfg_sel,
    input  logic [OSC_SIZE-1:0]   cfg_bx,
    output logic                  ro_enable,
    output logic [OSC_SIZE-1:0]   ro_sel,
    output logic [OSC_SIZE-1:0]   ro_bx,
    input  logic [NUM_RO-1:0]     ro_in,
    output logic                  busy,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [NUM_RO/2-1:0]   response,
    output logic [NUM_RO/2-1:0]   tie
);

    localparam int c_NPAIR = NUM_RO / 2;
    localparam int c_MAX_A = (SETTLE > WINDOW) ? SETTLE : WINDOW;
    localparam int c_MAX   = (c_MAX_A > c_NPAIR) ? c_MAX_A : c_NPAIR;
    localparam int c_PH_W  = $clog2(c_MAX + 1);

    localparam logic [c_PH_W-1:0] c_SETTLE_LAST = c_PH_W'(SETTLE - 1);
    localparam logic [c_PH_W-1:0] c_WINDOW_LAST = c_PH_W'(WINDOW - 1);
    localparam logic [c_PH_W-1:0] c_PAIR_LAST   = c_PH_W'(c_NPAIR - 1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX     = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_COUNT   = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_PH_W-1:0]    r_phase;
    logic                 w_accept;
    logic [NUM_RO-1:0]    r_sync1;
    logic [NUM_RO-1:0]    r_sync2;
    logic [NUM_RO-1:0]    r_hist;
    logic [NUM_RO-1:0]    w_rise;
    logic [CNT_W-1:0]     r_cnt [NUM_RO];

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_rise   = r_sync2 & ~r_hist;

    always_comb begin
        w_next     = r_state;
        ro_enable  = 1'b0;
        busy       = 1'b1;
        resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_SETTLE;
            end
            S_SETTLE: begin
                ro_enable = 1'b1;
                if (r_phase == c_SETTLE_LAST) w_next = S_COUNT;
            end
            S_COUNT: begin
                ro_enable = 1'b1;
                if (r_phase == c_WINDOW_LAST) w_next = S_COMPARE;
            end
            S_COMPARE: begin
                if (r_phase == c_PAIR_LAST) w_next = S_DONE;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Phase counter restarts on every state change; doubles as the pair index.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_phase <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state || r_state == S_IDLE || r_state == S_DONE)
                r_phase <= '0;
            else
                r_phase <= r_phase + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            ro_sel <= '0;
            ro_bx  <= '0;
        end else if (w_accept) begin
            ro_sel <= cfg_sel;
            ro_bx  <= cfg_bx;
        end
    end

    // Synchroniser and history run continuously so no stale edge appears at COUNT entry.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_hist  <= '0;
        end else begin
            r_sync1 <= ro_in;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    // Inputs at or above CLK/2 alias; counts are only meaningful below that rate.
    always_ff @(posedge CLK) begin
        if (!rst_n || w_accept) begin
            for (int i = 0; i < NUM_RO; i++) r_cnt[i] <= '0;
        end else if (r_state == S_COUNT) begin
            for (int i = 0; i < NUM_RO; i++) begin
                if (w_rise[i] && r_cnt[i] != c_CNT_MAX)
                    r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n || w_accept) begin
            response <= '0;
            tie      <= '0;
        end else if (r_state == S_COMPARE) begin
            for (int k = 0; k < c_NPAIR; k++) begin
                if (r_phase == c_PH_W'(k)) begin
                    response[k] <= (r_cnt[2*k] > r_cnt[2*k+1]);
                    tie[k]      <= (r_cnt[2*k] == r_cnt[2*k+1]);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ro_puf_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_ro_puf_engine
// Description : Directed self-checking bench for ro_puf_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ro_puf_engine;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rst_n;

    // Instance A: two oscillators, 16-bit counters
    logic        start_a, ready_a;
    logic [15:0] sel_a, bx_a, ro_sel_a, ro_bx_a;
    logic        ro_en_a, busy_a, valid_a;
    logic [1:0]  ro_a = '0;
    logic [0:0]  resp_a, tie_a;

    // Instances B (eight oscillators) and C (4-bit counters) share start/ready
    logic        start_bc, ready_bc;
    logic [15:0] cfg_bc;
    logic [15:0] ro_sel_b, ro_bx_b, ro_sel_c, ro_bx_c;
    logic        ro_en_b, busy_b, valid_b, ro_en_c, busy_c, valid_c;
    logic [7:0]  ro_b = '0;
    logic [1:0]  ro_c = '0;
    logic [3:0]  resp_b, tie_b;
    logic [0:0]  resp_c, tie_c;

    int per_a [2];
    int per_b [8];
    int per_c [2];
    int cyc = 0;

    int n_checks = 0;
    int n_errors = 0;

    ro_puf_engine #(.NUM_RO(2), .OSC_SIZE(16), .CNT_W(16), .WINDOW(64), .SETTLE(4)) u_a (
        .CLK(CLK), .rst_n(rst_n), .start(start_a), .cfg_sel(sel_a), .cfg_bx(bx_a),
        .ro_enable(ro_en_a), .ro_sel(ro_sel_a), .ro_bx(ro_bx_a), .ro_in(ro_a),
        .busy(busy_a), .resp_valid(valid_a), .resp_ready(ready_a),
        .response(resp_a), .tie(tie_a));

    ro_puf_engine #(.NUM_RO(8), .OSC_SIZE(16), .CNT_W(16), .WINDOW(64), .SETTLE(4)) u_b (
        .CLK(CLK), .rst_n(rst_n), .start(start_bc), .cfg_sel(cfg_bc), .cfg_bx(cfg_bc),
        .ro_enable(ro_en_b), .ro_sel(ro_sel_b), .ro_bx(ro_bx_b), .ro_in(ro_b),
        .busy(busy_b), .resp_valid(valid_b), .resp_ready(ready_bc),
        .response(resp_b), .tie(tie_b));

    ro_puf_engine #(.NUM_RO(2), .OSC_SIZE(16), .CNT_W(4), .WINDOW(64), .SETTLE(4)) u_c (
        .CLK(CLK), .rst_n(rst_n), .start(start_bc), .cfg_sel(cfg_bc), .cfg_bx(cfg_bc),
        .ro_enable(ro_en_c), .ro_sel(ro_sel_c), .ro_bx(ro_bx_c), .ro_in(ro_c),
        .busy(busy_c), .resp_valid(valid_c), .resp_ready(ready_bc),
        .response(resp_c), .tie(tie_c));

    // Square wave of period p CLK cycles (p = 0 holds the line low)
    function automatic logic sq(input int c, input int p);
        if (p == 0) return 1'b0;
        return (c % p) < (p / 2);
    endfunction

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) ro_a[i] <= sq(cyc, per_a[i]);
        for (int i = 0; i < 8; i++) ro_b[i] <= sq(cyc, per_b[i]);
        for (int i = 0; i < 2; i++) ro_c[i] <= sq(cyc, per_c[i]);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        int n;
        int hits;
        int unstable;
        int hi;

        rst_n = 1'b0; start_a = 1'b0; ready_a = 1'b0; start_bc = 1'b0; ready_bc = 1'b0;
        sel_a = 16'h1111; bx_a = 16'h2222; cfg_bc = 16'h0000;
        per_a = '{4, 6};
        per_b = '{4, 4, 8, 4, 4, 8, 0, 0};
        per_c = '{2, 2};

        repeat (3) @(negedge CLK);
        chk("rst_enable", {31'd0, ro_en_a}, 32'd0);
        chk("rst_busy",   {31'd0, busy_a},  32'd0);
        chk("rst_valid",  {31'd0, valid_a}, 32'd0);
        chk("rst_sel",    {16'd0, ro_sel_a}, 32'd0);
        chk("rst_bx",     {16'd0, ro_bx_a},  32'd0);
        chk("rst_resp_tie", {30'd0, resp_a, tie_a}, 32'd0);
        rst_n = 1'b1;

        // Reset aborts a measurement in COUNT
        @(negedge CLK); start_a = 1'b1;
        @(negedge CLK); start_a = 1'b0;
        chk("abort_busy_up", {31'd0, busy_a}, 32'd1);
        repeat (14) @(negedge CLK);
        chk("abort_in_count_enable", {31'd0, ro_en_a}, 32'd1);
        rst_n = 1'b0;
        @(negedge CLK);
        rst_n = 1'b1;
        chk("abort_enable", {31'd0, ro_en_a}, 32'd0);
        chk("abort_busy",   {31'd0, busy_a},  32'd0);
        chk("abort_valid",  {31'd0, valid_a}, 32'd0);
        chk("abort_sel",    {16'd0, ro_sel_a}, 32'd0);
        hits = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            if (valid_a || busy_a) hits++;
        end
        chk("abort_no_response", hits, 0);

        // Basic compare, latency, config latch
        sel_a = 16'hA5A5; bx_a = 16'h0F0F;
        @(negedge CLK); start_a = 1'b1;
        @(negedge CLK); start_a = 1'b0;
        chk("basic_busy_up", {31'd0, busy_a}, 32'd1);
        n = 0;
        while (!valid_a && n < 5000) begin
            @(negedge CLK);
            n++;
            if (n == 20) begin sel_a = 16'h1234; bx_a = 16'h5678; end
            if (n == 30) begin
                chk("latch_sel_count", {16'd0, ro_sel_a}, 32'h0000A5A5);
                chk("latch_bx_count",  {16'd0, ro_bx_a},  32'h00000F0F);
                chk("count_enable",    {31'd0, ro_en_a},  32'd1);
            end
        end
        chk("latency", n, 69);
        chk("basic_resp", {31'd0, resp_a}, 32'd1);
        chk("basic_tie",  {31'd0, tie_a},  32'd0);
        chk("done_enable", {31'd0, ro_en_a}, 32'd0);

        // Hold in DONE with ready low; a start pulse must be ignored
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            start_a = (i == 10);
            @(negedge CLK);
            if (!valid_a || !busy_a || resp_a !== 1'b1 || tie_a !== 1'b0) unstable++;
        end
        start_a = 1'b0;
        chk("done_stable", unstable, 0);
        chk("done_sel_hold", {16'd0, ro_sel_a}, 32'h0000A5A5);
        ready_a = 1'b1;
        @(negedge CLK);
        chk("accept_valid", {31'd0, valid_a}, 32'd0);
        chk("accept_busy",  {31'd0, busy_a},  32'd0);
        @(negedge CLK);
        chk("no_queued_start", {31'd0, busy_a}, 32'd0);
        chk("idle_sel_hold", {16'd0, ro_sel_a}, 32'h0000A5A5);
        chk("idle_bx_hold",  {16'd0, ro_bx_a},  32'h00000F0F);

        // Second run: slower first oscillator, ready already high
        per_a = '{6, 4};
        @(negedge CLK); start_a = 1'b1;
        @(negedge CLK); start_a = 1'b0;
        chk("relatch_sel", {16'd0, ro_sel_a}, 32'h00001234);
        chk("relatch_bx",  {16'd0, ro_bx_a},  32'h00005678);
        n = 0;
        while (!valid_a && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        chk("latency2", n, 69);
        chk("swap_resp", {31'd0, resp_a}, 32'd0);
        chk("swap_tie",  {31'd0, tie_a},  32'd0);
        hi = 0;
        while (valid_a && hi < 10) begin
            @(negedge CLK);
            hi++;
        end
        chk("single_valid_cycle", hi, 1);
        ready_a = 1'b0;

        // Tie/ordering (B) and saturation (C)
        @(negedge CLK); start_bc = 1'b1;
        @(negedge CLK); start_bc = 1'b0;
        n = 0;
        while (!(valid_b && valid_c) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        chk("bc_valid", {30'd0, valid_b, valid_c}, 32'd3);
        chk("order_resp", {28'd0, resp_b}, 32'h4);
        chk("order_tie",  {28'd0, tie_b},  32'h9);
        chk("sat_resp", {31'd0, resp_c}, 32'd0);
        chk("sat_tie",  {31'd0, tie_c},  32'd1);
        ready_bc = 1'b1;
        @(negedge CLK);
        ready_bc = 1'b0;
        chk("bc_accept", {30'd0, busy_b, busy_c}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
